// File: rtl/trace_uart_buf_pkg.sv
// Shared constants and types for the trace UART.
// Register map, bit positions and shifter states.
package trace_pkg;

  localparam logic [3:0] REG_CR = 4'd0;
  localparam logic [3:0] REG_SR = 4'd1;
  localparam logic [3:0] REG_TD = 4'd2;

  localparam int unsigned CR_EN     = 16;
  localparam int unsigned CR_BLOCK  = 17;
  localparam int unsigned CR_FLUSH  = 18;
  localparam int unsigned CR_IRQ_EN = 19;

  localparam int unsigned SR_IDLE  = 0;
  localparam int unsigned SR_FULL  = 1;
  localparam int unsigned SR_EMPTY = 2;
  localparam int unsigned SR_OVF   = 3;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } tx_state_e;

endpackage

// File: rtl/trace_uart_buf_if.sv
// MMIO bus bundle between the CPU and the trace UART.
// Signal names follow the peripheral's view of the bus.
interface trace_uart_buf_if;

  logic        select_i;
  logic [3:0]  mem_wstrb_i;
  logic [31:0] mem_addr_i;
  logic [31:0] mem_wdata_i;
  logic [31:0] mem_rdata_o;
  logic        mem_ready_o;

  modport master (
    output select_i,
    output mem_wstrb_i,
    output mem_addr_i,
    output mem_wdata_i,
    input  mem_rdata_o,
    input  mem_ready_o
  );

  modport slave (
    input  select_i,
    input  mem_wstrb_i,
    input  mem_addr_i,
    input  mem_wdata_i,
    output mem_rdata_o,
    output mem_ready_o
  );

endinterface

// File: rtl/trace_uart_buf_fifo.sv
// First-word-fall-through sync FIFO for the TX path.
// Flush has priority over push and pop.
module trace_fifo #(
  parameter  int DEPTH = 16,
  parameter  int WIDTH = 8,
  localparam int AW    = $clog2(DEPTH),
  localparam int LW    = AW + 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [LW-1:0]    level
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic [LW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == LW'(DEPTH));
  assign empty   = (count == '0);
  assign level   = count;
  assign rdata   = mem[rptr];
  assign do_push = push & ~full & ~flush;
  assign do_pop  = pop & ~empty & ~flush;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else if (flush) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + AW'(1);
      if (do_pop)  rptr <= rptr + AW'(1);
      if (do_push && !do_pop)
        count <= count + LW'(1);
      else if (do_pop && !do_push)
        count <= count - LW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem[wptr] <= wdata;
  end

endmodule

// File: rtl/trace_uart_buf.sv
// Buffered 8N1 trace UART transmitter on the MMIO bus.
// Bus decode, CR/SR registers, baud counter and shifter FSM.
module trace_uart_buf
  import trace_pkg::*;
#(
  parameter int FIFO_DEPTH  = 16,
  parameter int DIV_W       = 16,
  parameter int DEFAULT_DIV = 233
) (
  input  logic            clk_i,
  input  logic            rst_i,
  trace_uart_buf_if.slave bus,
  output logic            trace_o,
  output logic            irq_o
);

  localparam int LW = $clog2(FIFO_DEPTH) + 1;

  logic [3:0]       idx;
  logic             wr;
  logic             td_wr;
  logic             cr_wr;
  logic             sr_wr;
  logic             pending;
  logic             accept;
  logic             push;
  logic             flush;
  logic             done;
  logic             ready;
  logic [31:0]      rdata;
  logic [31:0]      cr_val;
  logic [31:0]      sr_val;
  logic [31:0]      rd_val;
  logic [DIV_W-1:0] div;
  logic             en;
  logic             block;
  logic             irq_en;
  logic             ovf;
  logic             pop;
  logic             full;
  logic             empty;
  logic [7:0]       fifo_rdata;
  logic [LW-1:0]    level;
  tx_state_e        state;
  tx_state_e        state_n;
  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] div_lat;
  logic [2:0]       bitn;
  logic [7:0]       shreg;
  logic             trace_q;
  logic             line;
  logic             bit_end;
  logic             can_start;
  logic             idle;
  logic             unused_bits;

  assign idx   = bus.mem_addr_i[5:2];
  assign wr    = |bus.mem_wstrb_i;
  assign td_wr = wr & (idx == REG_TD);
  assign cr_wr = wr & (idx == REG_CR);
  assign sr_wr = wr & (idx == REG_SR);

  // done keeps a held select from starting a second access
  assign pending = bus.select_i & ~ready & ~done;
  assign accept  = pending & ~(td_wr & full & block);
  assign push    = accept & td_wr & ~full;
  assign flush   = accept & cr_wr & bus.mem_wdata_i[CR_FLUSH];

  assign unused_bits = ^{bus.mem_addr_i[31:6],
                         bus.mem_addr_i[1:0],
                         bus.mem_wdata_i[31:20]};

  assign bus.mem_ready_o = ready;
  assign bus.mem_rdata_o = rdata;
  assign idle            = (state == IDLE) & empty;
  assign irq_o           = irq_en & idle;
  assign trace_o         = trace_q;

  always_comb begin
    cr_val            = '0;
    cr_val[DIV_W-1:0] = div;
    cr_val[CR_EN]     = en;
    cr_val[CR_BLOCK]  = block;
    cr_val[CR_IRQ_EN] = irq_en;
    sr_val            = '0;
    sr_val[SR_IDLE]   = idle;
    sr_val[SR_FULL]   = full;
    sr_val[SR_EMPTY]  = empty;
    sr_val[SR_OVF]    = ovf;
    sr_val[15:8]      = 8'(level);
  end

  always_comb begin
    rd_val = '0;
    unique case (1'b1)
      (idx == REG_CR): rd_val = cr_val;
      (idx == REG_SR): rd_val = sr_val;
      default:         rd_val = '0;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ready <= 1'b0;
      done  <= 1'b0;
      rdata <= '0;
    end else begin
      ready <= accept;
      rdata <= (accept && !wr) ? rd_val : '0;
      if (accept)
        done <= 1'b1;
      else if (!bus.select_i)
        done <= 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      div    <= DIV_W'(DEFAULT_DIV);
      en     <= 1'b1;
      block  <= 1'b0;
      irq_en <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      if (accept && cr_wr) begin
        div    <= bus.mem_wdata_i[DIV_W-1:0];
        en     <= bus.mem_wdata_i[CR_EN];
        block  <= bus.mem_wdata_i[CR_BLOCK];
        irq_en <= bus.mem_wdata_i[CR_IRQ_EN];
      end
      if (accept && td_wr && full)
        ovf <= 1'b1;
      else if (accept && sr_wr && bus.mem_wdata_i[SR_OVF])
        ovf <= 1'b0;
    end
  end

  trace_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .push  (push),
    .pop   (pop),
    .flush (flush),
    .wdata (bus.mem_wdata_i[7:0]),
    .rdata (fifo_rdata),
    .full  (full),
    .empty (empty),
    .level (level)
  );

  // a flush in the same cycle cancels the start, so FIFO and shifter agree
  assign can_start = en & ~empty & ~flush;
  assign bit_end   = (cnt == div_lat);

  always_comb begin
    state_n = state;
    pop     = 1'b0;
    line    = 1'b1;
    unique case (state)
      IDLE: begin
        if (can_start) begin
          pop     = 1'b1;
          state_n = START;
        end
      end
      START: begin
        line = 1'b0;
        if (bit_end) state_n = DATA;
      end
      DATA: begin
        line = shreg[0];
        if (bit_end && bitn == 3'd7) state_n = STOP;
      end
      STOP: begin
        if (bit_end) begin
          if (can_start) begin
            pop     = 1'b1;
            state_n = START;
          end else begin
            state_n = IDLE;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state   <= IDLE;
      trace_q <= 1'b1;
      cnt     <= '0;
      div_lat <= '0;
      bitn    <= '0;
      shreg   <= '0;
    end else begin
      state   <= state_n;
      trace_q <= line;
      if (pop) begin
        shreg   <= fifo_rdata;
        div_lat <= div;
        cnt     <= '0;
        bitn    <= '0;
      end else if (state != IDLE) begin
        if (bit_end) begin
          cnt <= '0;
          if (state == DATA) begin
            shreg <= shreg >> 1;
            bitn  <= bitn + 3'd1;
          end
        end else begin
          cnt <= cnt + DIV_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_trace_uart_buf.sv
// Bench for trace_uart_buf: register vectors, serial decoder,
// queue model of the TX FIFO and directed corner sequences.
module tb_trace_uart_buf;

  logic clk = 1'b0;
  logic rst;
  logic trace;
  logic irq;

  always #5 clk = ~clk;

  trace_uart_buf_if bus ();

  trace_uart_buf dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .bus     (bus),
    .trace_o (trace),
    .irq_o   (irq)
  );

  int checks = 0;
  int passes = 0;
  int cyc    = 0;
  int rx_div = 233;
  logic [7:0] rx_q [$];
  int         rx_t [$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  function automatic logic [31:0] rxb(int i);
    return (i < rx_q.size()) ? 32'(rx_q[i]) : 32'hFFFF_FFFF;
  endfunction

  // serial decoder: samples each bit at its centre
  initial begin
    logic [7:0] b;
    int d;
    int t0;
    forever begin
      @(posedge clk); #1;
      if (rst !== 1'b1 && trace === 1'b0) begin
        d  = rx_div;
        t0 = cyc;
        for (int i = 0; i < 8; i++) begin
          repeat ((i == 0) ? d + 1 + d / 2 : d + 1) begin
            @(posedge clk); #1;
          end
          b[i] = trace;
        end
        repeat (d + 1) begin
          @(posedge clk); #1;
        end
        chk("rx_stop", 32'(trace), 32'd1);
        rx_q.push_back(b);
        rx_t.push_back(t0);
      end
    end
  end

  task automatic bus_acc(input logic w, input logic [3:0] idx,
                         input logic [31:0] wd,
                         output logic [31:0] rd, output int lat);
    @(negedge clk);
    bus.select_i    = 1'b1;
    bus.mem_wstrb_i = w ? 4'hF : 4'h0;
    bus.mem_addr_i  = {26'd0, idx, 2'd0};
    bus.mem_wdata_i = wd;
    lat = 0;
    rd  = '0;
    while (lat < 5000) begin
      @(posedge clk); #1;
      lat++;
      if (bus.mem_ready_o) break;
    end
    if (!bus.mem_ready_o) chk("bus_timeout", 32'd0, 32'd1);
    rd = bus.mem_rdata_o;
    bus.select_i    = 1'b0;
    bus.mem_wstrb_i = 4'h0;
    @(posedge clk); #1;
  endtask

  task automatic wr(input logic [3:0] idx, input logic [31:0] wd);
    logic [31:0] r;
    int l;
    bus_acc(1'b1, idx, wd, r, l);
  endtask

  task automatic rd(input logic [3:0] idx, input logic [31:0] exp,
                    input string nm);
    logic [31:0] r;
    int l;
    bus_acc(1'b0, idx, 32'd0, r, l);
    chk(nm, r, exp);
  endtask

  task automatic wait_idle(input string nm);
    logic [31:0] r;
    int l;
    int n;
    n = 0;
    do begin
      bus_acc(1'b0, 4'd1, 32'd0, r, l);
      n++;
    end while (!r[0] && n < 3000);
    chk(nm, 32'(r[0]), 32'd1);
    repeat (20) @(posedge clk);
    #1;
  endtask

  typedef struct {
    bit          w;
    logic [3:0]  idx;
    logic [31:0] wd;
    logic [31:0] exp;
    string       nm;
  } vec_t;

  vec_t tbl [10];

  initial begin
    logic [31:0] r;
    logic [7:0]  exp_q [$];
    logic [7:0]  bv;
    int lat;
    int bad;
    int waited;
    logic got;
    logic prev;
    int n;
    int d;
    int keep;

    tbl[0] = '{1'b0, 4'd0, 32'h0, 32'h0001_00E9, "rst_cr"};
    tbl[1] = '{1'b0, 4'd1, 32'h0, 32'h0000_0005, "rst_sr"};
    tbl[2] = '{1'b0, 4'd2, 32'h0, 32'h0000_0000, "rd_td"};
    tbl[3] = '{1'b0, 4'd7, 32'h0, 32'h0000_0000, "rd_idx7"};
    tbl[4] = '{1'b1, 4'd0, 32'h000D_0007, 32'h0, "w_cr"};
    tbl[5] = '{1'b0, 4'd0, 32'h0, 32'h0009_0007, "cr_flush_rd0"};
    tbl[6] = '{1'b0, 4'd1, 32'h0, 32'h0000_0005, "sr_after_flush"};
    tbl[7] = '{1'b1, 4'd0, 32'h0001_0003, 32'h0, "w_cr2"};
    tbl[8] = '{1'b1, 4'd9, 32'hFFFF_FFFF, 32'h0, "w_unmapped"};
    tbl[9] = '{1'b0, 4'd0, 32'h0, 32'h0001_0003, "cr_unchanged"};

    rst = 1'b0;
    bus.select_i    = 1'b0;
    bus.mem_wstrb_i = 4'h0;
    bus.mem_addr_i  = 32'h0;
    bus.mem_wdata_i = 32'h0;
    #2 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_trace", 32'(trace), 32'd1);
    chk("rst_ready", 32'(bus.mem_ready_o), 32'd0);
    chk("rst_rdata", bus.mem_rdata_o, 32'd0);
    chk("rst_irq", 32'(irq), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 10; i++) begin
      bus_acc(tbl[i].w, tbl[i].idx, tbl[i].wd, r, lat);
      if (!tbl[i].w) chk(tbl[i].nm, r, tbl[i].exp);
      if (i == 4) chk("irq_idle", 32'(irq), 32'd1);
    end
    chk("irq_off", 32'(irq), 32'd0);

    // T1: single frame, DIV=3
    rx_div = 3;
    rx_q.delete();
    wr(4'd2, 32'h55);
    chk("t1_high_1clk", 32'(trace), 32'd1);
    @(posedge clk); #1;
    chk("t1_start_2clk", 32'(trace), 32'd0);
    bv = 8'h55;
    for (int i = 0; i < 8; i++) begin
      repeat (4) @(posedge clk);
      #1;
      chk($sformatf("t1_bit%0d", i), 32'(trace), 32'(bv[i]));
    end
    repeat (4) @(posedge clk);
    #1;
    chk("t1_stop", 32'(trace), 32'd1);
    repeat (6) @(posedge clk);
    rd(4'd1, 32'h5, "t1_sr_idle");
    chk("t1_rx", rxb(0), 32'h55);

    // T2: EN=0, overflow with drop policy, then drain
    rx_div = 1;
    wr(4'd0, 32'h0000_0001);
    rx_q.delete();
    rx_t.delete();
    for (int i = 0; i < 17; i++) wr(4'd2, 32'(i));
    rd(4'd1, 32'h0000_100A, "t2_sr_full_ovf");
    wr(4'd0, 32'h0001_0001);
    wait_idle("t2_idle");
    chk("t2_count", rx_q.size(), 32'd16);
    bad = 0;
    for (int i = 0; i < 16; i++)
      if (rxb(i) != 32'(i)) bad++;
    chk("t2_bytes", bad, 32'd0);
    bad = 0;
    for (int i = 1; i < rx_t.size(); i++)
      if (rx_t[i] - rx_t[i-1] != 20) bad++;
    chk("t2_no_gap", bad, 32'd0);
    rd(4'd1, 32'h0000_000D, "t2_ovf_sticky");
    wr(4'd1, 32'h8);
    rd(4'd1, 32'h0000_0005, "t2_ovf_clr");

    // T3: blocking write while full
    rx_div = 9;
    wr(4'd0, 32'h0003_0009);
    rx_q.delete();
    for (int i = 0; i < 17; i++) wr(4'd2, 32'(8'h30 + i));
    rd(4'd1, 32'h0000_1002, "t3_sr_full");
    @(negedge clk);
    bus.select_i    = 1'b1;
    bus.mem_wstrb_i = 4'hF;
    bus.mem_addr_i  = 32'h8;
    bus.mem_wdata_i = 32'hA5;
    prev   = trace;
    waited = 0;
    got    = 1'b0;
    while (waited < 1000) begin
      @(posedge clk); #1;
      waited++;
      if (bus.mem_ready_o) begin
        got = 1'b1;
        break;
      end
      prev = trace;
    end
    chk("t3_ready", 32'(got), 32'd1);
    chk("t3_held_low", 32'(waited > 20), 32'd1);
    chk("t3_ready_at_start", 32'(trace), 32'd0);
    chk("t3_prev_stop", 32'(prev), 32'd1);
    bus.select_i    = 1'b0;
    bus.mem_wstrb_i = 4'h0;
    @(posedge clk); #1;
    wait_idle("t3_idle");
    chk("t3_count", rx_q.size(), 32'd18);
    chk("t3_last", rxb(17), 32'hA5);
    chk("t3_first", rxb(0), 32'h30);

    // T4: flush mid-frame
    wr(4'd0, 32'h0001_0009);
    rx_q.delete();
    for (int i = 0; i < 5; i++) wr(4'd2, 32'(8'h61 + i));
    repeat (30) @(posedge clk);
    wr(4'd0, 32'h0005_0009);
    rd(4'd1, 32'h0000_0004, "t4_sr_flushed");
    wait_idle("t4_idle");
    repeat (100) @(posedge clk);
    chk("t4_count", rx_q.size(), 32'd1);
    chk("t4_frame0", rxb(0), 32'h61);

    // randomized: blocking policy, everything must arrive in order
    for (int rnd = 0; rnd < 3; rnd++) begin
      d = $urandom_range(0, 4);
      rx_div = d;
      wr(4'd0, 32'h0003_0000 | 32'(d));
      rx_q.delete();
      exp_q.delete();
      n = $urandom_range(4, 20);
      for (int i = 0; i < n; i++) begin
        bv = 8'($urandom);
        exp_q.push_back(bv);
        wr(4'd2, 32'(bv));
      end
      wait_idle("rnd_idle");
      bad = (rx_q.size() == exp_q.size()) ? 0 : 1;
      for (int i = 0; i < exp_q.size(); i++)
        if (rxb(i) != 32'(exp_q[i])) bad++;
      chk($sformatf("rnd_block%0d", rnd), bad, 32'd0);
    end

    // randomized: drop policy with transmitter disabled
    for (int rnd = 0; rnd < 2; rnd++) begin
      d = $urandom_range(0, 3);
      rx_div = d;
      wr(4'd0, 32'(d));
      rx_q.delete();
      exp_q.delete();
      n = $urandom_range(10, 24);
      for (int i = 0; i < n; i++) begin
        bv = 8'($urandom);
        if (exp_q.size() < 16) exp_q.push_back(bv);
        wr(4'd2, 32'(bv));
      end
      keep = exp_q.size();
      rd(4'd1, (32'(keep) << 8) | ((keep == 16) ? 32'h2 : 32'h0)
               | ((n > 16) ? 32'h8 : 32'h0),
         $sformatf("rnd_drop_sr%0d", rnd));
      wr(4'd0, 32'h0001_0000 | 32'(d));
      wait_idle("rnd_drop_idle");
      bad = (rx_q.size() == exp_q.size()) ? 0 : 1;
      for (int i = 0; i < exp_q.size(); i++)
        if (rxb(i) != 32'(exp_q[i])) bad++;
      chk($sformatf("rnd_drop%0d", rnd), bad, 32'd0);
      wr(4'd1, 32'h8);
    end

    // T5: async reset mid-DATA
    rx_div = 9;
    wr(4'd0, 32'h0001_0009);
    wr(4'd2, 32'h00);
    repeat (45) @(posedge clk);
    #1;
    chk("t5_data_low", 32'(trace), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("t5_async_high", 32'(trace), 32'd1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    rd(4'd0, 32'h0001_00E9, "t5_cr");
    rd(4'd1, 32'h0000_0005, "t5_sr");
    repeat (150) @(posedge clk);
    rx_q.delete();

    // T6: unmapped latency, held select gives one push
    bus_acc(1'b0, 4'd7, 32'd0, r, lat);
    chk("t6_rdata", r, 32'd0);
    chk("t6_latency", lat, 32'd1);
    wr(4'd0, 32'h0);
    @(negedge clk);
    bus.select_i    = 1'b1;
    bus.mem_wstrb_i = 4'hF;
    bus.mem_addr_i  = 32'h8;
    bus.mem_wdata_i = 32'h77;
    repeat (3) @(posedge clk);
    #1;
    bus.select_i    = 1'b0;
    bus.mem_wstrb_i = 4'h0;
    @(posedge clk); #1;
    rd(4'd1, 32'h0000_0100, "t6_one_push");

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
